// File: rtl/uart_alarm_cmd_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_alarm_cmd_parser
// Brief    : Parses "Ahh:mm<CR|LF>" alarm-set frames from the UART byte
//            stream and answers each decided frame with 'K' or 'E'.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alarm_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic [4:0] uart_alarm_hour,
    output logic [5:0] uart_alarm_minute,
    output logic       is_uart_set,
    output logic       cmd_err
);

    localparam logic [7:0]  c_ACK      = 8'h4B;
    localparam logic [7:0]  c_NAK      = 8'h45;
    localparam logic [26:0] c_TMO_LAST = 27'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HT   = 3'd1,
        S_HU   = 3'd2,
        S_COL  = 3'd3,
        S_MT   = 3'd4,
        S_MU   = 3'd5,
        S_END  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [26:0] r_tmo_cnt;
    logic [3:0]  r_ht, r_hu, r_mt, r_mu;
    logic [4:0]  r_hour;
    logic [5:0]  r_min;
    logic        r_set, r_err, r_tx_valid;
    logic [7:0]  r_tx_data;

    logic        w_is_start, w_is_digit, w_is_term, w_match;
    logic        w_timeout, w_accept, w_reject;
    logic [5:0]  w_hour6, w_min6;

    assign w_is_start = (rx_data == 8'h41) || (rx_data == 8'h61);
    assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);

    // ht <= 2 and mt <= 5 keep both sums inside 6 bits
    assign w_hour6 = ({2'b00, r_ht} << 3) + ({2'b00, r_ht} << 1) + {2'b00, r_hu};
    assign w_min6  = ({2'b00, r_mt} << 3) + ({2'b00, r_mt} << 1) + {2'b00, r_mu};

    assign w_timeout = (r_state != S_IDLE) && !rx_valid && (r_tmo_cnt == c_TMO_LAST);

    always_comb begin
        w_match = 1'b0;
        case (r_state)
            S_IDLE:  w_match = w_is_start;
            S_HT:    w_match = w_is_digit && (rx_data <= 8'h32);
            S_HU:    w_match = w_is_digit;
            S_COL:   w_match = (rx_data == 8'h3A);
            S_MT:    w_match = w_is_digit && (rx_data <= 8'h35);
            S_MU:    w_match = w_is_digit;
            S_END:   w_match = w_is_term;
            default: w_match = 1'b0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        if (rx_valid) begin
            if (w_match) begin
                case (r_state)
                    S_IDLE:  w_next = S_HT;
                    S_HT:    w_next = S_HU;
                    S_HU:    w_next = S_COL;
                    S_COL:   w_next = S_MT;
                    S_MT:    w_next = S_MU;
                    S_MU:    w_next = S_END;
                    S_END: begin
                        w_next = S_IDLE;
                        if (w_hour6 <= 6'd23) begin
                            w_accept = 1'b1;
                        end else begin
                            w_reject = 1'b1;
                        end
                    end
                    default: w_next = S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                // the offending byte may itself open a new frame
                w_reject = 1'b1;
                w_next   = w_is_start ? S_HT : S_IDLE;
            end
        end else if (w_timeout) begin
            w_reject = 1'b1;
            w_next   = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tmo_cnt  <= '0;
            r_ht       <= '0;
            r_hu       <= '0;
            r_mt       <= '0;
            r_mu       <= '0;
            r_hour     <= '0;
            r_min      <= '0;
            r_set      <= 1'b0;
            r_err      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state <= w_next;
            r_set   <= w_accept;
            r_err   <= w_reject;

            if (rx_valid || (w_next == S_IDLE)) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 27'd1;
            end

            if (rx_valid && w_match) begin
                case (r_state)
                    S_HT:    r_ht <= rx_data[3:0];
                    S_HU:    r_hu <= rx_data[3:0];
                    S_MT:    r_mt <= rx_data[3:0];
                    S_MU:    r_mu <= rx_data[3:0];
                    default: ;
                endcase
            end

            if (w_accept) begin
                r_hour <= w_hour6[4:0];
                r_min  <= w_min6;
            end

            // a fresh response overrides both a pending one and its handshake
            if (w_accept || w_reject) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_accept ? c_ACK : c_NAK;
            end else if (r_tx_valid && tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    assign tx_data           = r_tx_data;
    assign tx_valid          = r_tx_valid;
    assign uart_alarm_hour   = r_hour;
    assign uart_alarm_minute = r_min;
    assign is_uart_set       = r_set;
    assign cmd_err           = r_err;

endmodule
`default_nettype wire

// File: doc/uart_alarm_cmd_parser.md
# uart_alarm_cmd_parser

Byte-level command decoder between the UART receiver and `alarm_control`. It parses ASCII alarm-set frames of the form `Ahh:mm<CR|LF>` from the received byte stream. On a valid frame it drives `uart_alarm_hour`, `uart_alarm_minute` and the one-cycle `is_uart_set` strobe consumed by `alarm_control`. It returns a one-byte acknowledgement (`K` accepted / `E` rejected) to the UART transmitter over a valid/ready handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100_000_000: maximum idle cycles between bytes inside a frame (1 s at 100 MHz); valid range 2 to 2^27−1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `tx_ready`  in  1  the transmitter accepts `tx_data` in a cycle where `tx_valid && tx_ready`.
- `tx_data`  out  8  response byte: 0x4B `K` or 0x45 `E`.
- `tx_valid`  out  1  response pending.
- `uart_alarm_hour`  out  5  last accepted hour, 0–23.
- `uart_alarm_minute`  out  6  last accepted minute, 0–59.
- `is_uart_set`  out  1  one-cycle strobe: a frame was accepted.
- `cmd_err`  out  1  one-cycle strobe: a frame was rejected or timed out.

## Operation
- FSM states and the byte each state expects:
  - S_IDLE: `A` (0x41) or `a` (0x61).
  - S_HT: `0`–`2`.
  - S_HU: `0`–`9`.
  - S_COL: `:` (0x3A).
  - S_MT: `0`–`5`.
  - S_MU: `0`–`9`.
  - S_END: CR (0x0D) or LF (0x0A).
- The FSM advances only on `rx_valid`, when the byte matches the current state's expected set.
- In S_IDLE, any non-start byte is silently ignored. There is no error and no response.
- Digit capture:
  - `hour = ht*10 + hu`, computed in 5 bits; the 6-bit intermediate must not overflow.
  - `min = mt*10 + mu`, 6 bits.
  - Digits are held in 4-bit staging registers. Output registers change only on acceptance.
- Range check at S_END: a frame is accepted when the terminator arrives and hour ≤ 23. Minutes are ≤ 59 by construction. Hour 24–29 rejects the frame.
- On accept:
  - Load `uart_alarm_hour` and `uart_alarm_minute`.
  - Pulse `is_uart_set`.
  - Queue `K`.
  - Go to S_IDLE.
- On reject:
  - Triggers: a mismatching byte in any non-IDLE state, a range failure, or a timeout.
  - Pulse `cmd_err`, queue `E`, go to S_IDLE. Outputs keep their previous values.
- Restart on a bad byte: the mismatching byte is re-evaluated as if in S_IDLE. So `A` both rejects the current frame and starts a new one (next state S_HT).
- Timeout:
  - A 27-bit counter clears on every `rx_valid` and on entering S_IDLE, and increments otherwise while not in S_IDLE.
  - When the counter reaches `TIMEOUT_CYCLES−1`, this is a reject.
- Response buffer:
  - One entry deep. `tx_valid` stays high until `tx_valid && tx_ready`.
  - A new response while one is still pending overwrites `tx_data`; `tx_valid` stays high.
  - Acceptance and a new response in the same cycle: the new response wins and `tx_valid` stays 1.

## Timing
- Reset (`rst_n` = 0 at a clock edge), applicable at any point including mid-frame:
  - State S_IDLE; timeout counter 0; staging digits 0.
  - `uart_alarm_hour` = 0, `uart_alarm_minute` = 0.
  - `is_uart_set` = 0, `cmd_err` = 0, `tx_valid` = 0, `tx_data` = 0x00.
  - A partial frame is discarded with no response.
- Latency: `is_uart_set`, `cmd_err`, the new hour/minute values and `tx_valid` are registered. They become visible the cycle after the `rx_valid` cycle of the deciding byte.
- `uart_alarm_hour` and `uart_alarm_minute` are stable in the same cycle `is_uart_set` is high, and remain stable afterwards.
- `is_uart_set` and `cmd_err` are exactly 1 cycle wide and never high together.
- Back-to-back `rx_valid` on consecutive cycles is fully supported; there is no throughput limit.
- `rx_valid` in the same cycle as timeout expiry: the byte wins. The counter clears and the byte is processed normally, with no timeout.
- `tx_ready` is not required for parsing. Parsing never stalls on the transmitter.

## Test plan
- Send `A07:30\r` with bytes 3 cycles apart -> one cycle after CR: `is_uart_set` = 1 for 1 cycle, hour = 7, minute = 30, `tx_data` = 0x4B, `tx_valid` = 1 until `tx_ready` is pulsed.
- Send `a23:59\n` back-to-back, then `A24:00\r` -> first frame accepted (23, 59). Second frame: `cmd_err` pulse and `E` queued; outputs stay at 23/59.
- Send `A1` then `A05:05\r` -> `cmd_err` on the second `A`. The new frame is accepted (5, 5); responses `E` then `K` (overwrite if `tx_ready` is held low).
- With `TIMEOUT_CYCLES` = 16: send `A12`, then wait 16 cycles -> `cmd_err` pulses and state returns to S_IDLE. A byte arriving exactly on the expiry cycle prevents the timeout.
- Assert `rst_n` = 0 after `A12:3` -> all outputs go to their reset values next edge. Sending `4\r` afterwards produces no response.
- Noise `xyz` in S_IDLE, then `A00:00\r` -> no `cmd_err` for the noise; frame accepted with hour = 0, minute = 0.
